// File: rtl/fc_stream_pkg.sv
// Shared types and helpers for the fc stream host: FSM state encoding and
// the saturating stall-counter increment.
package fc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == STALL_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fc_host_buf.sv
// Small register-array buffer: async clear, synchronous write, combinational
// read. Reads (and writes) outside DEPTH are ignored / return zero.
module fc_host_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int RAW   = AW
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_we,
    input  logic [AW-1:0]           i_waddr,
    input  logic signed [WIDTH-1:0] i_wdata,
    input  logic [RAW-1:0]          i_raddr,
    output logic signed [WIDTH-1:0] o_rdata
);

    localparam logic [AW:0]  W_LIMIT = (AW+1)'(DEPTH);
    localparam logic [RAW:0] R_LIMIT = (RAW+1)'(DEPTH);

    logic signed [WIDTH-1:0] r_mem [DEPTH];
    logic                    w_wr_ok;
    logic                    w_rd_ok;

    assign w_wr_ok = ({1'b0, i_waddr} < W_LIMIT);
    assign w_rd_ok = ({1'b0, i_raddr} < R_LIMIT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = w_rd_ok ? r_mem[i_raddr[AW-1:0]] : '0;

endmodule

// File: rtl/fc_stream_host.sv
// Stream host for an fc layer: sends a stored N-word vector over a
// valid/ready stream, then collects M result words into a readable buffer.
module fc_stream_host
    import fc_stream_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8,
    parameter int T = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [$clog2(N)-1:0]  i_wr_addr,
    input  logic signed [T-1:0]   i_wr_data,
    input  logic                  i_start,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic signed [T-1:0]   o_tx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic signed [T-1:0]   i_rx_data,
    input  logic [$clog2(M):0]    i_rd_addr,
    output logic signed [T-1:0]   o_rd_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [STALL_W-1:0]    o_stall_cnt
);

    localparam int TXW = $clog2(N);
    localparam int RXW = $clog2(M);
    localparam logic [TXW-1:0] TX_LAST = TXW'(N - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(M - 1);

    state_t               r_state;
    state_t               w_next;
    logic [TXW-1:0]       r_tx_cnt;
    logic [RXW-1:0]       r_rx_cnt;
    logic [STALL_W-1:0]   r_stall_cnt;

    logic                 w_tx_hs;
    logic                 w_rx_hs;
    logic                 w_vbuf_we;
    logic signed [T-1:0]  w_vbuf_rd;

    // Handshake strobes are qualified by registered state only, so the
    // outgoing valid/ready never depend combinationally on the far side.
    assign w_tx_hs   = (r_state == SEND) && i_tx_ready;
    assign w_rx_hs   = (r_state == RECV) && i_rx_valid;
    assign w_vbuf_we = (r_state == IDLE) && i_wr_en;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_start) w_next = SEND;
            SEND: if (w_tx_hs && (r_tx_cnt == TX_LAST)) w_next = RECV;
            RECV: if (w_rx_hs && (r_rx_cnt == RX_LAST)) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_tx_cnt    <= '0;
                        r_stall_cnt <= '0;
                    end
                end
                SEND: begin
                    if (!i_tx_ready) begin
                        r_stall_cnt <= sat_inc(r_stall_cnt);
                    end
                    if (w_tx_hs) begin
                        if (r_tx_cnt == TX_LAST) begin
                            r_tx_cnt <= '0;
                            r_rx_cnt <= '0;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (w_rx_hs) begin
                        r_rx_cnt <= (r_rx_cnt == RX_LAST) ? '0 : r_rx_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    fc_host_buf #(
        .WIDTH (T),
        .DEPTH (N),
        .AW    (TXW),
        .RAW   (TXW)
    ) u_vbuf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_vbuf_we),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data),
        .i_raddr (r_tx_cnt),
        .o_rdata (w_vbuf_rd)
    );

    // Read address carries one extra bit so out-of-range indices are expressible.
    fc_host_buf #(
        .WIDTH (T),
        .DEPTH (M),
        .AW    (RXW),
        .RAW   (RXW + 1)
    ) u_rbuf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_rx_hs),
        .i_waddr (r_rx_cnt),
        .i_wdata (i_rx_data),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

    assign o_tx_valid  = (r_state == SEND);
    assign o_tx_data   = o_tx_valid ? w_vbuf_rd : '0;
    assign o_rx_ready  = (r_state == RECV);
    assign o_busy      = (r_state == SEND) || (r_state == RECV);
    assign o_done      = (r_state == DONE);
    assign o_stall_cnt = r_stall_cnt;

endmodule
